// File: rtl/norm_pkg.sv
// ---------------------------------------------------------------------------
// norm_pkg : shared types and constants for the SFP row normalisation sequencer
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package norm_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACC_RD   = 3'd1,
    S_ACC_WAIT = 3'd2,
    S_SYNC     = 3'd3,
    S_DIV_RD   = 3'd4,
    S_DIV_WAIT = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  localparam int MAX_LEN   = 16;
  localparam int ACC_DRAIN = 2;
  localparam int DIV_DRAIN = 2;

endpackage

`default_nettype wire

// File: rtl/norm_addr_gen.sv
// ---------------------------------------------------------------------------
// norm_addr_gen : base latch plus modulo-wrapping incrementing address counter
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module norm_addr_gen #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              restart,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Restart rewinds to the latched base so the second pass revisits the same addresses.
  always_comb begin
    base_d = base_q;
    addr_d = addr_q;
    if (load) begin
      base_d = base;
      addr_d = base;
    end else if (restart) begin
      addr_d = base_q;
    end else if (inc) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      addr_q <= '0;
    end else begin
      base_q <= base_d;
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

`default_nettype wire

// File: rtl/norm_seq.sv
// ---------------------------------------------------------------------------
// norm_seq : two-pass accumulate/divide sequencer for one SFP row with peer sync.
// Optional SYNC timeout enabled by defining NORM_SEQ_TIMEOUT_EN.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module norm_seq #(
  parameter int ADDR_W  = 11,
  parameter int MAX_LEN = norm_pkg::MAX_LEN,
  parameter int LEN_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic              peer_rdy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              acc,
  output logic              div,
  output logic              fifo_ext_rd,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              sync_rdy,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import norm_pkg::*;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             rd_en_q, rd_en_d;
  logic             phase_q, phase_d;
  logic             acc_q, acc_d;
  logic             div_q, div_d;
  logic             fifo_q, fifo_d;
  logic             wr_en_q, wr_en_d;
  logic             sync_q, sync_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;
  logic             rd_restart;
  logic             len_ok;

  assign len_ok = (len != '0) && (32'(len) <= MAX_LEN);

`ifdef NORM_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    err_d      = 1'b0;
    accept     = 1'b0;
    rd_restart = 1'b0;
`ifdef NORM_SEQ_TIMEOUT_EN
    tmo_d      = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            accept  = 1'b1;
            len_d   = len;
            cnt_d   = '0;
            state_d = S_ACC_RD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ACC_RD: begin
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q == len_q - LEN_W'(1)) begin
          cnt_d   = '0;
          state_d = S_ACC_WAIT;
        end
      end
      S_ACC_WAIT: begin
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q == LEN_W'(ACC_DRAIN - 1)) begin
          cnt_d   = '0;
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (peer_rdy) begin
          rd_restart = 1'b1;
          state_d    = S_DIV_RD;
        end
`ifdef NORM_SEQ_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      S_DIV_RD: begin
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q == len_q - LEN_W'(1)) begin
          cnt_d   = '0;
          state_d = S_DIV_WAIT;
        end
      end
      S_DIV_WAIT: begin
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q == LEN_W'(DIV_DRAIN - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are flopped from the next state so they line up with the state register.
    rd_en_d = (state_d == S_ACC_RD) || (state_d == S_DIV_RD);
    phase_d = (state_d == S_DIV_RD);
    acc_d   = rd_en_q && !phase_q;
    div_d   = rd_en_q && phase_q;
    fifo_d  = div_q;
    wr_en_d = div_q;
    sync_d  = (state_d == S_SYNC);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      rd_en_q <= 1'b0;
      phase_q <= 1'b0;
      acc_q   <= 1'b0;
      div_q   <= 1'b0;
      fifo_q  <= 1'b0;
      wr_en_q <= 1'b0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      rd_en_q <= rd_en_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      fifo_q  <= fifo_d;
      wr_en_q <= wr_en_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  norm_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .base    (rd_base),
    .restart (rd_restart),
    .inc     (rd_en_q),
    .addr    (rd_addr)
  );

  norm_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .base    (wr_base),
    .restart (1'b0),
    .inc     (wr_en_q),
    .addr    (wr_addr)
  );

  assign rd_en       = rd_en_q;
  assign acc         = acc_q;
  assign div         = div_q;
  assign fifo_ext_rd = fifo_q;
  assign wr_en       = wr_en_q;
  assign sync_rdy    = sync_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_norm_seq.sv
// ---------------------------------------------------------------------------
// tb_norm_seq : randomized self-checking bench for norm_seq against a
// cycle-timeline reference model. Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_norm_seq;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [4:0]    len_i;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] wr_base;
  logic          peer_rdy;
  logic          rd_en, acc, div, fifo_ext_rd, wr_en, sync_rdy, busy, done, err;
  logic [AW-1:0] rd_addr, wr_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  norm_seq #(.ADDR_W(AW), .MAX_LEN(16), .LEN_W(5), .TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .len         (len_i),
    .rd_base     (rd_base),
    .wr_base     (wr_base),
    .peer_rdy    (peer_rdy),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .acc         (acc),
    .div         (div),
    .fifo_ext_rd (fifo_ext_rd),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .sync_rdy    (sync_rdy),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  function automatic logic [8:0] obs_flags();
    return {rd_en, acc, div, fifo_ext_rd, wr_en, sync_rdy, busy, done, err};
  endfunction

  // Drives one legal tile (start at cycle 0, peer high from cycle p) and checks
  // every cycle against the timeline derived from the tile parameters.
  task automatic run_tile(input int n, input int rb, input int wb, input int p,
                          input bit noise);
    int s, e, d, last;
    logic [8:0] exp_f;
    logic [AW-1:0] exp_ra, exp_wa;
    s = n + 3;
    e = (p > s) ? p : s;
    d = e + 1;
    last = d + n + 4;
    for (int t = 0; t <= last; t++) begin
      if (t == 0) begin
        start   = 1'b1;
        len_i   = 5'(n);
        rd_base = AW'(rb);
        wr_base = AW'(wb);
      end else begin
        start   = noise && (t <= d + n + 2) && ($urandom_range(0, 1) == 1);
        len_i   = 5'($urandom_range(0, 31));
        rd_base = AW'($urandom);
        wr_base = AW'($urandom);
      end
      peer_rdy = (t >= p);
      @(negedge clk);
      exp_f[8] = (t >= 1 && t <= n) || (t >= d && t <= d + n - 1);
      exp_f[7] = (t >= 2 && t <= n + 1);
      exp_f[6] = (t >= d + 1 && t <= d + n);
      exp_f[5] = (t >= d + 2 && t <= d + n + 1);
      exp_f[4] = exp_f[5];
      exp_f[3] = (t >= s && t <= e);
      exp_f[2] = (t >= 1 && t <= d + n + 2);
      exp_f[1] = (t == d + n + 2);
      exp_f[0] = 1'b0;
      vectors++;
      if (obs_flags() !== exp_f) begin
        miscompares++;
        $display("FAIL tile_flags n=%0d p=%0d t=%0d got=%b want=%b (rd_en,acc,div,fifo,wr_en,sync,busy,done,err)",
                 n, p, t, obs_flags(), exp_f);
      end
      if (exp_f[8]) begin
        exp_ra = (t <= n) ? AW'(rb + t - 1) : AW'(rb + t - d);
        vectors++;
        if (rd_addr !== exp_ra) begin
          miscompares++;
          $display("FAIL rd_addr n=%0d t=%0d got=%h want=%h", n, t, rd_addr, exp_ra);
        end
      end
      if (exp_f[4]) begin
        exp_wa = AW'(wb + t - d - 2);
        vectors++;
        if (wr_addr !== exp_wa) begin
          miscompares++;
          $display("FAIL wr_addr n=%0d t=%0d got=%h want=%h", n, t, wr_addr, exp_wa);
        end
      end
      @(posedge clk); #1;
    end
    start    = 1'b0;
    peer_rdy = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; len_i = '0; rd_base = '0; wr_base = '0; peer_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({obs_flags(), rd_addr, wr_addr} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs got=%b/%h/%h want=0", obs_flags(), rd_addr, wr_addr);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    run_tile(4, 'h010, 'h100, 0, 1'b0);
  endtask

  task automatic test_late_peer();
    run_tile(4, 'h020, 'h200, 12, 1'b0);
  endtask

  task automatic test_illegal_len();
    int bad [3];
    bad[0] = 0; bad[1] = 17; bad[2] = int'($urandom_range(18, 31));
    foreach (bad[k]) begin
      for (int t = 0; t <= 3; t++) begin
        start = (t == 0);
        len_i = 5'(bad[k]);
        @(negedge clk);
        vectors++;
        if (obs_flags() !== ((t == 1) ? 9'b000000001 : 9'b0)) begin
          miscompares++;
          $display("FAIL illegal_len len=%0d t=%0d got=%b want_err=%0d", bad[k], t, obs_flags(), (t == 1));
        end
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_max_wrap();
    run_tile(16, 'h7FE, 'h7F8, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++)
      run_tile(int'($urandom_range(1, 16)), int'($urandom_range(0, 2047)),
               int'($urandom_range(0, 2047)), int'($urandom_range(0, 20)), 1'b1);
  endtask

  task automatic test_reset_mid_div();
    for (int t = 0; t <= 11; t++) begin
      start   = (t == 0);
      len_i   = 5'd4;
      rd_base = AW'('h030);
      wr_base = AW'('h300);
      reset   = (t == 10);
      @(negedge clk);
      if (t == 11) begin
        vectors++;
        if ({obs_flags(), rd_addr, wr_addr} !== '0) begin
          miscompares++;
          $display("FAIL reset_mid_div got=%b/%h/%h want=0", obs_flags(), rd_addr, wr_addr);
        end
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    start = 1'b0;
    run_tile(4, 'h040, 'h400, 0, 1'b0);
  endtask

`ifdef NORM_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [8:0] exp_f;
    for (int t = 0; t <= 16; t++) begin
      start    = (t == 0);
      len_i    = 5'd2;
      peer_rdy = 1'b0;
      @(negedge clk);
      exp_f = '0;
      exp_f[8] = (t >= 1 && t <= 2);
      exp_f[7] = (t >= 2 && t <= 3);
      exp_f[3] = (t >= 5 && t <= 12);
      exp_f[2] = (t >= 1 && t <= 13);
      exp_f[1] = (t == 13);
      exp_f[0] = (t == 13);
      vectors++;
      if (obs_flags() !== exp_f) begin
        miscompares++;
        $display("FAIL timeout t=%0d got=%b want=%b", t, obs_flags(), exp_f);
      end
      @(posedge clk); #1;
    end
    start    = 1'b0;
    peer_rdy = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_late_peer();
    test_illegal_len();
    test_max_wrap();
    test_back_to_back();
    test_reset_mid_div();
`ifdef NORM_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
